// File: rtl/maxpool_row_pair_buffer.sv
// Collects an even row and the following odd row of pixels and presents them as one wide row-pair bus.
// Latency: out_valid rises the cycle after the last odd-row pixel is accepted; one mandatory OUT bubble per pair.
// Backpressure: in_ready is low while a pair is pending; out_ready=0 holds the pair indefinitely.
module maxpool_row_pair_buffer #(
    parameter int DATA_BITS = 32,
    parameter int D         = 1,
    parameter int W         = 48,
    parameter int H         = 48
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [D*DATA_BITS-1:0]       in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*W*D*DATA_BITS-1:0]   out_data,
    output logic                         out_last
);

    localparam int COL_W  = (W > 1) ? $clog2(W) : 1;
    localparam int PAIR_W = (H / 2 > 1) ? $clog2(H / 2) : 1;

    typedef enum logic [1:0] {
        FILL_TOP,
        FILL_BOT,
        OUT
    } state_t;

    state_t                        state_q;
    state_t                        state_d;
    logic [COL_W-1:0]              col_q;
    logic [PAIR_W-1:0]             pair_q;
    logic [2*W*D*DATA_BITS-1:0]    pair_buf_q;
    logic                          accept;
    logic                          transfer;
    logic                          col_end;
    logic                          pair_end;
    int                            row_sel;

    assign col_end  = (col_q == COL_W'(W - 1));
    assign pair_end = (pair_q == PAIR_W'(H / 2 - 1));
    assign accept   = in_valid & in_ready;
    assign transfer = out_valid & out_ready;
    assign row_sel  = (state_q == FILL_BOT) ? 1 : 0;
    assign out_data = pair_buf_q;
    assign out_last = out_valid & pair_end;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            FILL_TOP: begin
                in_ready = 1'b1;
                if (in_valid && col_end) state_d = FILL_BOT;
            end
            FILL_BOT: begin
                in_ready = 1'b1;
                if (in_valid && col_end) state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = FILL_TOP;
            end
            default: state_d = FILL_TOP;
        endcase
    end

    // Storage doubles as the output register; every slot is rewritten before the next OUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL_TOP;
            col_q      <= '0;
            pair_q     <= '0;
            pair_buf_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                col_q <= col_end ? '0 : col_q + COL_W'(1);
                for (int c = 0; c < D; c++) begin
                    pair_buf_q[(row_sel * D * W + c * W + int'(col_q)) * DATA_BITS +: DATA_BITS]
                        <= in_data[c * DATA_BITS +: DATA_BITS];
                end
            end
            if (transfer) begin
                pair_q <= pair_end ? '0 : pair_q + PAIR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_maxpool_row_pair_buffer.sv
// Directed and randomised checks of the row-pair buffer: W=4/H=4/D=1 main instance, W=2/H=2/D=2 layout instance.
module tb_maxpool_row_pair_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, out_last;
    logic [7:0]  in_data;
    logic [63:0] out_data;
    logic        in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
    logic [15:0] in_data2;
    logic [63:0] out_data2;

    int vectors;
    int miscompares;

    maxpool_row_pair_buffer #(.DATA_BITS(8), .D(1), .W(4), .H(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    maxpool_row_pair_buffer #(.DATA_BITS(8), .D(2), .W(2), .H(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_last(out_last2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] seq_pair(input logic [7:0] first);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = first + 8'(i);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feeds n consecutive pixel values starting at first; returns #1 after the last accept edge.
    task automatic feed(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            int wait_cyc;
            in_valid = 1'b1;
            in_data  = first + 8'(i);
            wait_cyc = 0;
            while (!in_ready && wait_cyc < 20) begin
                step();
                wait_cyc++;
            end
            if (!in_ready) begin
                vectors++;
                miscompares++;
                $display("FAIL feed_wait: in_ready stayed %b, required 1", in_ready);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b last=%b ready=%b data=%h, required 0 0 1 0",
                     out_valid, out_last, in_ready, out_data);
        end
    endtask

    task automatic test_first_pair();
        out_ready = 1'b1;
        feed(8'h01, 8);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pair0_handshake: valid=%b ready=%b, required 1 0", out_valid, in_ready);
        end
        vectors++;
        if (out_data !== seq_pair(8'h01) || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL pair0_data: data=%h last=%b, required %h 0", out_data, out_last, seq_pair(8'h01));
        end
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL pair0_one_cycle: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_last_and_wrap();
        feed(8'h11, 8);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== seq_pair(8'h11) || out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL pair1_last: valid=%b data=%h last=%b, required 1 %h 1",
                     out_valid, out_data, out_last, seq_pair(8'h11));
        end
        step();
        feed(8'h31, 8);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== seq_pair(8'h31) || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_pair: valid=%b data=%h last=%b, required 1 %h 0",
                     out_valid, out_data, out_last, seq_pair(8'h31));
        end
        step();
    endtask

    task automatic test_channel_layout();
        logic [15:0] beats [4];
        beats[0] = 16'hB0A0;
        beats[1] = 16'hB1A1;
        beats[2] = 16'hB3A2;
        beats[3] = 16'hB4A3;
        out_ready2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid2 = 1'b1;
            in_data2  = beats[i];
            vectors++;
            if (in_ready2 !== 1'b1) begin
                miscompares++;
                $display("FAIL layout_ready beat %0d: in_ready=%b, required 1", i, in_ready2);
            end
            step();
        end
        in_valid2 = 1'b0;
        vectors++;
        if (out_valid2 !== 1'b1 || out_data2 !== 64'hB4B3A3A2B1B0A1A0 || out_last2 !== 1'b1) begin
            miscompares++;
            $display("FAIL layout_data: valid=%b data=%h last=%b, required 1 b4b3a3a2b1b0a1a0 1",
                     out_valid2, out_data2, out_last2);
        end
        out_ready2 = 1'b1;
        step();
        vectors++;
        if (out_valid2 !== 1'b0) begin
            miscompares++;
            $display("FAIL layout_release: valid=%b, required 0", out_valid2);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        feed(8'h41, 8);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== seq_pair(8'h41) || out_last !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold cycle %0d: valid=%b ready=%b data=%h last=%b, required 1 0 %h 1",
                         i, out_valid, in_ready, out_data, out_last, seq_pair(8'h41));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_random_stream();
        logic [63:0] q[$];
        logic [63:0] cur;
        logic [63:0] exp;
        int k, produced, got;
        k = 0;
        produced = 0;
        got = 0;
        cur = '0;
        for (int cyc = 0; cyc < 3000 && got < 6; cyc++) begin
            in_valid  = (produced < 48) && ($urandom_range(0, 1) == 1);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            if (in_valid && in_ready) begin
                cur[k*8 +: 8] = in_data;
                k++;
                produced++;
                if (k == 8) begin
                    q.push_back(cur);
                    k = 0;
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_spurious pair %0d: data=%h with no pair expected", got, out_data);
                end else begin
                    exp = q.pop_front();
                    if (out_data !== exp || out_last !== (got % 2 == 1)) begin
                        miscompares++;
                        $display("FAIL rand_pair %0d: data=%h last=%b, required %h %b",
                                 got, out_data, out_last, exp, (got % 2 == 1));
                    end
                end
                got++;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (got != 6) begin
            miscompares++;
            $display("FAIL rand_count: %0d pairs transferred, required 6", got);
        end
    endtask

    task automatic test_reset_recovery();
        out_ready = 1'b0;
        feed(8'h61, 8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_out: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        feed(8'h91, 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        feed(8'h21, 8);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== seq_pair(8'h21) || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fresh_pair: valid=%b data=%h last=%b, required 1 %h 0",
                     out_valid, out_data, out_last, seq_pair(8'h21));
        end
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        in_valid2   = 1'b0;
        in_data2    = '0;
        out_ready2  = 1'b0;

        test_reset();
        test_first_pair();
        test_last_and_wrap();
        test_channel_layout();
        test_backpressure();
        test_random_stream();
        test_reset_recovery();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
